fetch_sequencer: RTL and testbench

- Program-counter sequencer and fetch buffer in front of the combinational instruction memory (CodeMem: pc in, instr out, same cycle).
- Owns the PC: drives it to the memory, captures the returned word and its PC into a 2-entry FIFO, and presents them to decode over a valid/ready handshake.
- Handles start, branch redirect (with flush), halt, and misaligned-redirect fault; sits between CodeMem and the decode stage of the sequential core.

---
 rtl/fetch_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_sequencer: PC sequencer and 2-entry fetch buffer for CodeMem.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault
);

  localparam logic [1:0]  c_ST_IDLE   = 2'd0;
  localparam logic [1:0]  c_ST_FETCH  = 2'd1;
  localparam logic [1:0]  c_ST_HALTED = 2'd2;

  localparam int unsigned c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_CW = $clog2(DEPTH + 1);
  localparam logic [31:0] c_PC_STEP = 32'(PC_STEP);
  localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(DEPTH - 1);
  localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);

  logic [1:0]      state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [c_CW-1:0] count_q, count_d;
  logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [31:0]     fifo_pc_q    [DEPTH];

  logic fetch_en;
  logic redir_act;
  logic redir_bad;
  logic fifo_full;
  logic pop_en;
  logic push_en;

  // Redirects only take effect once the core has been started at least once.
  assign redir_act = redirect_valid && (state_q != c_ST_IDLE);
  assign redir_bad = redir_act && (redirect_pc[1:0] != 2'b00);
  assign fifo_full = (count_q == c_FULL_CNT);
  assign pop_en    = out_valid && out_ready && !redir_act;
  assign push_en   = fetch_en && !redir_act && !halt_req && (!fifo_full || pop_en);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (start && !halt_req) begin
          state_d = c_ST_FETCH;
        end
      end
      c_ST_FETCH: begin
        if (redir_bad) begin
          state_d = c_ST_HALTED;
        end else if (redir_act) begin
          state_d = c_ST_FETCH;
        end else if (halt_req) begin
          state_d = c_ST_HALTED;
        end
      end
      c_ST_HALTED: begin
        if (!redir_act && !halt_req && start && !fault_q) begin
          state_d = c_ST_FETCH;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // ---------------- state-decoded outputs ----------------
  always_comb begin
    fetch_en = 1'b0;
    halted   = 1'b0;
    case (state_q)
      c_ST_FETCH:  fetch_en = 1'b1;
      c_ST_HALTED: halted   = 1'b1;
      default: begin
        fetch_en = 1'b0;
        halted   = 1'b0;
      end
    endcase
  end

  // ---------------- PC, fault and FIFO bookkeeping ----------------
  always_comb begin
    pc_d     = pc_q;
    fault_d  = fault_q | redir_bad;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (redir_act) begin
      // A misaligned target faults without moving the PC; both cases flush.
      if (!redir_bad) begin
        pc_d = redirect_pc;
      end
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_en) begin
        pc_d     = pc_q + c_PC_STEP;
        wr_ptr_d = (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_d = (rd_ptr_q == c_LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      fault_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head outputs are never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (push_en) begin
      fifo_instr_q[wr_ptr_q] <= mem_instr;
      fifo_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign mem_pc    = pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = fifo_instr_q[rd_ptr_q];
  assign out_pc    = fifo_pc_q[rd_ptr_q];
  assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_sequencer: directed + random bench with a queue-based model.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam logic [31:0] c_KEY = 32'hA5A5_0000;
  localparam int c_M_IDLE   = 0;
  localparam int c_M_FETCH  = 1;
  localparam int c_M_HALTED = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] mem_pc;
  logic [31:0] mem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        fault;

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_pc         (mem_pc),
    .mem_instr      (mem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational code memory.
  assign mem_instr = mem_pc ^ c_KEY;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  int          m_state;
  logic        m_fault;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, driven by the current inputs.
  task automatic model_edge();
    bit do_pop;
    bit do_push;
    if (rst) begin
      m_q.delete();
      m_pc    = 32'h0;
      m_state = c_M_IDLE;
      m_fault = 1'b0;
      return;
    end
    do_pop = (m_q.size() > 0) && out_ready;
    if (redirect_valid && m_state != c_M_IDLE) begin
      m_q.delete();
      if (redirect_pc[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_state = c_M_HALTED;
      end else begin
        m_pc = redirect_pc;
      end
      return;
    end
    do_push = (m_state == c_M_FETCH) && !halt_req && (m_q.size() < 2 || do_pop);
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back('{pc: m_pc, instr: m_pc ^ c_KEY});
      m_pc = m_pc + 32'd4;
    end
    if (halt_req) begin
      if (m_state == c_M_FETCH) m_state = c_M_HALTED;
    end else if (start) begin
      if (m_state == c_M_IDLE || (m_state == c_M_HALTED && !m_fault)) m_state = c_M_FETCH;
    end
  endtask

  task automatic compare_all();
    check("mem_pc", mem_pc, m_pc);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
    check("halted", {31'b0, halted}, {31'b0, m_state == c_M_HALTED});
    check("fault", {31'b0, fault}, {31'b0, m_fault});
    if (m_q.size() > 0) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_instr", out_instr, m_q[0].instr);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; out_ready = 0; redirect_valid = 0;
    redirect_pc = 0; halt_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    m_pc = 0; m_state = c_M_IDLE; m_fault = 0;

    // Reset state and registered head outputs.
    do_reset();
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);

    // Streaming at one instruction per cycle.
    out_ready = 1; start = 1; step();
    start = 0; step();
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_pc", out_pc, 32'h0);
    step(); check("stream_pc1", out_pc, 32'h4);
    step(); check("stream_pc2", out_pc, 32'h8);
    step(); check("stream_pc3", out_pc, 32'hC);

    // Back-pressure saturates the FIFO, then drains without bubbles.
    do_reset();
    start = 1; step(); start = 0;
    repeat (4) step();
    check("full_mem_pc", mem_pc, 32'h8);
    check("full_out_pc", out_pc, 32'h0);
    out_ready = 1;
    step(); check("drain_pc1", out_pc, 32'h4);
    step(); check("drain_pc2", out_pc, 32'h8);

    // Redirect while full.
    out_ready = 0; repeat (3) step();
    redirect_valid = 1; redirect_pc = 32'h100; step();
    redirect_valid = 0;
    check("redir_flush", {31'b0, out_valid}, 32'd0);
    check("redir_mem_pc", mem_pc, 32'h100);
    step();
    check("redir_out_pc", out_pc, 32'h100);

    // Halt with two entries queued, drain, then resume.
    step();
    halt_req = 1; step(); halt_req = 0;
    check("halt_halted", {31'b0, halted}, 32'd1);
    out_ready = 1; repeat (3) step();
    check("halt_drained", {31'b0, out_valid}, 32'd0);
    check("halt_frozen_pc", mem_pc, 32'h108);
    start = 1; step(); start = 0;
    repeat (3) step();

    // Misaligned redirect: sticky fault, start ignored.
    redirect_valid = 1; redirect_pc = 32'h102; step(); redirect_valid = 0;
    check("mis_fault", {31'b0, fault}, 32'd1);
    check("mis_halted", {31'b0, halted}, 32'd1);
    start = 1; step(); start = 0;
    check("mis_still_halted", {31'b0, halted}, 32'd1);
    repeat (2) step();

    // Reset beats a simultaneous redirect.
    rst = 1; redirect_valid = 1; redirect_pc = 32'h200; step();
    rst = 0; redirect_valid = 0;
    check("rst_mid_pc", mem_pc, 32'h0);
    check("rst_mid_fault", {31'b0, fault}, 32'd0);

    // PC wrap-around.
    start = 1; step(); start = 0;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; step(); redirect_valid = 0;
    out_ready = 1; step();
    check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc1", out_pc, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) < 1);
      start          = ($urandom_range(0, 99) < 8);
      halt_req       = ($urandom_range(0, 99) < 4);
      out_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 4))
        0:       redirect_pc = $urandom();
        1:       redirect_pc = 32'hFFFF_FFF0 | {26'b0, $urandom_range(0, 3), 2'b00};
        default: redirect_pc = {$urandom_range(0, 32'h3FFF), 2'b00};
      endcase
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
